tcm_ahb_swc: RTL and testbench
==============================

# tcm_ahb_swc

AHB-lite subordinate tightly-coupled memory: the responder end of the core's instruction and data fetch buses. It holds a word-organised RAM, accepts pipelined single transfers (byte, halfword, word), inserts a configurable number of wait states, and returns ERROR for illegal accesses. One instance serves ITCM, another DTCM, inside the SoC wrapper around the core.

## Interface
- ADDR_WIDTH, 10, word-address bits; capacity is 2^ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000, byte base address; must be aligned to the region size.
- WAIT_STATES, 0, extra data-phase cycles per OKAY transfer; legal range 0–3.
- hclk  in  1  clock; all logic is on the rising edge.
- hrstn  in  1  synchronous active-low reset.
- hsel  in  1  slave select.
- haddr  in  32  byte address.
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  in  1  1 = write.
- hsize  in  3  0 = byte, 1 = half, 2 = word; values >2 are illegal.
- hburst  in  3  ignored; every beat is handled as a single transfer.
- hprot  in  7  ignored.
- hmastlock  in  1  ignored.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus-level HREADY; the previous data phase on the bus is complete.
- hreadyout  out  1  this slave's data phase is complete.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data.

## Operation
- Accept: when hsel & htrans[1] & hready on an edge, capture haddr, hwrite and hsize as the pending data phase. IDLE/BUSY transfers, and transfers seen while hready=0, are not captured and get a zero-wait OKAY.
- Legality: the address is in [BASE_ADDR, BASE_ADDR + 4·2^ADDR_WIDTH), hsize ≤ 2, and the access is naturally aligned (half: haddr[0]=0; word: haddr[1:0]=0). Any failure is an illegal access.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=0.
  - Legal accept (from any state with hreadyout=1) → WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0, else → DATA.
  - WAIT: hreadyout=0. Counter decrements each cycle; at 0 → DATA.
  - DATA: hreadyout=1, hresp=0; the transfer completes on this edge. Next state is set by the next accept (pipelined), else IDLE.
  - Illegal accept → ERR1 (hreadyout=0, hresp=1) → ERR2 (hreadyout=1, hresp=1) → next accept or IDLE. No wait states are inserted on errors. An illegal write never modifies memory.
- Write: commits at the DATA edge, using hwdata from that cycle. Lanes are little-endian:
  - byte → lane haddr[1:0];
  - half → lanes {haddr[1],1} and {haddr[1],0};
  - word → all four lanes.
  - Unselected bytes are unchanged.
- Read: the memory word is captured into hrdata on the accept edge. The read is captured only on a legal read accept; otherwise hrdata holds its value.
  - Forwarding: if a write commits on that same edge to the same word, hrdata gets the merged post-write word.
  - hrdata returns the full word; the master selects lanes.
- Reset (hrstn=0 on an edge): state=IDLE, hreadyout=1, hresp=0, hrdata=0, counter=0. Any pending transfer is dropped, including an uncommitted write. RAM contents are not reset.

## Timing
- Read latency with WAIT_STATES=0: address phase in cycle N, hrdata valid in cycle N+1 with hreadyout=1.
- With WAIT_STATES=k: hreadyout is low for k cycles, then high for one cycle. hrdata is stable from N+1 through completion.
- Back-to-back accepts are full throughput (one transfer per cycle) when WAIT_STATES=0.
- Error response is exactly 2 cycles. ERR1 never accepts a new address because hreadyout=0 there.
- Master changes to htrans/haddr during WAIT or ERR1 are ignored.
- hreadyout/hresp are registered (state-decoded); there is no combinational path from inputs.

## Test plan
- Reset then idle: hrstn=0 for 2 cycles → hreadyout=1, hresp=0, hrdata=0; IDLE htrans for 5 cycles → hreadyout stays 1, hresp=0.
- Word write/read, WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back → read data phase shows hrdata=0xDEADBEEF (forwarded), no stall.
- Byte/half lanes: word 0x10 = 0x00000000; sb 0xAA @0x11; sh 0x1234 @0x12 (hwdata 0x1234_0000) → read 0x10 = 0x1234AA00.
- Wait states, WAIT_STATES=2: read → hreadyout low 2 cycles then high 1 cycle. Three pipelined reads take 9 cycles.
- Errors, each → hresp=1 for 2 cycles, hreadyout 0 then 1, memory unchanged (verify by a following read):
  - misaligned word @0x12;
  - hsize=3;
  - address BASE_ADDR+4·2^ADDR_WIDTH.
- Reset mid-transfer: WAIT_STATES=3 write 0x5555_5555 @0x20; assert hrstn in the second wait cycle → the next read of 0x20 returns the old value and hreadyout=1 right after reset.

Source files
------------

// File: rtl/tcm_ahb_swc.sv
// AHB-lite subordinate tightly-coupled memory: word RAM with byte/half/word lanes,
// configurable data-phase wait states and a two-cycle ERROR response for illegal accesses.
module tcm_ahb_swc #(
   parameter int          ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        hclk,
   input  logic        hrstn,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [6:0]  hprot,
   input  logic        hmastlock,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t                  state_q, state_d;
   logic [1:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   idx_q;
   logic                    wr_q;
   logic [3:0]              be_q;
   logic [31:0]             hrdata_q;

   logic [31:0]             mem [2**ADDR_WIDTH];

   logic                    readyOut;
   logic                    accept;
   logic                    inRange;
   logic                    aligned;
   logic                    legal;
   logic                    commit;
   logic [ADDR_WIDTH-1:0]   acceptIdx;
   logic [3:0]              acceptBe;
   logic [31:0]             rdWord;
   logic                    unusedInputs;

   assign unusedInputs = ^{hburst, hprot, hmastlock};

   assign readyOut  = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
   assign hreadyout = readyOut;
   assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
   assign hrdata    = hrdata_q;

   // The slave's own hreadyout also gates acceptance so that address changes
   // during WAIT/ERR1 can never start a new transfer.
   assign accept    = hsel && htrans[1] && hready && readyOut;
   assign inRange   = (haddr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
   assign acceptIdx = haddr[ADDR_WIDTH+1:2];
   assign legal     = inRange && aligned;
   assign commit    = (state_q == S_DATA) && wr_q;

   always_comb begin
      aligned  = 1'b0;
      acceptBe = 4'b0000;
      case (hsize)
         3'd0: begin
            aligned  = 1'b1;
            acceptBe = 4'b0001 << haddr[1:0];
         end
         3'd1: begin
            aligned  = ~haddr[0];
            acceptBe = haddr[1] ? 4'b1100 : 4'b0011;
         end
         3'd2: begin
            aligned  = (haddr[1:0] == 2'b00);
            acceptBe = 4'b1111;
         end
         default: begin
            aligned  = 1'b0;
            acceptBe = 4'b0000;
         end
      endcase
   end

   // A write committing on the same edge as a read capture of the same word is forwarded.
   always_comb begin
      rdWord = mem[acceptIdx];
      if (commit && (idx_q == acceptIdx)) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
               rdWord[8*i +: 8] = hwdata[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         S_ERR1: begin
            state_d = S_ERR2;
         end
         default: begin
            if (accept) begin
               if (!legal) begin
                  state_d = S_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = 2'(WAIT_STATES - 1);
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge hclk) begin
      if (!hrstn) begin
         state_q  <= S_IDLE;
         cnt_q    <= 2'd0;
         idx_q    <= '0;
         wr_q     <= 1'b0;
         be_q     <= 4'b0000;
         hrdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept && legal) begin
            idx_q <= acceptIdx;
            wr_q  <= hwrite;
            be_q  <= acceptBe;
            if (!hwrite) begin
               hrdata_q <= rdWord;
            end
         end
      end
   end

   // RAM contents survive reset; a write still pending when reset hits is dropped.
   always_ff @(posedge hclk) begin
      if (hrstn && commit) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
               mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_tcm_ahb_swc.sv
// Randomised and directed bench for tcm_ahb_swc: three instances (0, 2, 3 wait states)
// share one AHB master, checked cycle by cycle against a transfer-level memory model.
module tb_tcm_ahb_swc;

   localparam int          AW     = 10;
   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam logic [31:0] REGION = 32'(4 * (1 << AW));

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [1:0]  trans;
      logic [31:0] wdata;
   } tx_t;

   logic        hclk = 1'b0;
   logic        hrstn;
   logic [2:0]  hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic [1:0]  selIdx;
   logic        hreadyBus;
   logic [2:0]  rdyVec;
   logic [2:0]  respVec;
   logic [31:0] rdata0, rdata1, rdata2;

   int          assertCount = 0;
   int          failCount   = 0;
   tx_t         txQ[$];
   logic [31:0] mdl [3][16];

   always #5 hclk = ~hclk;

   assign hreadyBus = rdyVec[selIdx];

   tcm_ahb_swc #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
      .hclk(hclk), .hrstn(hrstn), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(7'b0000000),
      .hmastlock(1'b0), .hwdata(hwdata), .hready(hreadyBus),
      .hreadyout(rdyVec[0]), .hresp(respVec[0]), .hrdata(rdata0));

   tcm_ahb_swc #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(2)) u_ws2 (
      .hclk(hclk), .hrstn(hrstn), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(7'b0000000),
      .hmastlock(1'b0), .hwdata(hwdata), .hready(hreadyBus),
      .hreadyout(rdyVec[1]), .hresp(respVec[1]), .hrdata(rdata1));

   tcm_ahb_swc #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_ws3 (
      .hclk(hclk), .hrstn(hrstn), .hsel(hsel[2]), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(7'b0000000),
      .hmastlock(1'b0), .hwdata(hwdata), .hready(hreadyBus),
      .hreadyout(rdyVec[2]), .hresp(respVec[2]), .hrdata(rdata2));

   function automatic int waitsOf(int d);
      return (d == 0) ? 0 : (d == 1) ? 2 : 3;
   endfunction

   function automatic logic [31:0] rdataOf(int d);
      return (d == 0) ? rdata0 : (d == 1) ? rdata1 : rdata2;
   endfunction

   function automatic bit isLegal(tx_t t);
      bit okAlign;
      okAlign = (t.size == 3'd0) || (t.size == 3'd1 && t.addr[0] == 1'b0) ||
                (t.size == 3'd2 && t.addr[1:0] == 2'b00);
      return ((t.addr - BASE) < REGION) && okAlign;
   endfunction

   function automatic logic [31:0] mergeWord(logic [31:0] old, tx_t t);
      logic [31:0] w;
      w = old;
      if (t.size == 3'd0) begin
         w[8*t.addr[1:0] +: 8] = t.wdata[8*t.addr[1:0] +: 8];
      end else if (t.size == 3'd1) begin
         if (t.addr[1]) w[31:16] = t.wdata[31:16];
         else           w[15:0]  = t.wdata[15:0];
      end else begin
         w = t.wdata;
      end
      return w;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic pushTx(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [31:0] wdata, input logic [1:0] trans);
      tx_t t;
      t.addr = addr; t.wr = wr; t.size = size; t.wdata = wdata; t.trans = trans;
      txQ.push_back(t);
   endtask

   // Pipelined AHB master: the next address phase is issued whenever the slave is ready,
   // and every data-phase cycle is compared against the model's expected response.
   task automatic applyStimulus(input int d, output int busyCycles);
      tx_t         cur;
      tx_t         nxt;
      bit          curValid;
      bit          curLegal;
      int          idx;
      logic [31:0] expRd;
      logic        r;
      logic        resp;
      logic [31:0] rd;
      curValid   = 1'b0;
      curLegal   = 1'b0;
      idx        = 0;
      expRd      = 32'h0;
      busyCycles = 0;
      selIdx     = 2'(d);
      while (txQ.size() > 0 || curValid) begin
         @(negedge hclk);
         r    = rdyVec[d];
         resp = respVec[d];
         rd   = rdataOf(d);
         if (curValid) begin
            busyCycles++;
            hwdata = cur.wdata;
            if (curLegal) begin
               checkOutput("dataReady", r, (idx == waitsOf(d)));
               checkOutput("dataResp", resp, 0);
               if (!cur.wr) checkOutput("hrdata", rd, expRd);
            end else begin
               checkOutput("errReady", r, (idx == 1));
               checkOutput("errResp", resp, 1);
            end
            idx++;
            if (idx > 6) begin
               checkOutput("dataPhaseBound", idx, 6);
               txQ.delete();
               curValid = 1'b0;
               hsel     = 3'b000;
               htrans   = 2'b00;
               break;
            end
         end else begin
            checkOutput("idleReady", r, 1);
            checkOutput("idleResp", resp, 0);
         end
         if (r) begin
            if (curValid && curLegal && cur.wr) begin
               mdl[d][cur.addr[5:2]] = mergeWord(mdl[d][cur.addr[5:2]], cur);
            end
            curValid = 1'b0;
            if (txQ.size() > 0) begin
               nxt    = txQ.pop_front();
               hsel   = 3'b001 << d;
               haddr  = nxt.addr;
               htrans = nxt.trans;
               hwrite = nxt.wr;
               hsize  = nxt.size;
               if (nxt.trans[1]) begin
                  cur      = nxt;
                  curValid = 1'b1;
                  curLegal = isLegal(nxt);
                  idx      = 0;
                  if (curLegal && !nxt.wr) expRd = mdl[d][nxt.addr[5:2]];
               end
            end else begin
               hsel   = 3'b000;
               htrans = 2'b00;
            end
         end
      end
   endtask

   initial begin
      int          cyc;
      logic [31:0] a;
      logic [2:0]  sz;
      hrstn  = 1'b0;
      hsel   = 3'b000;
      haddr  = 32'h0;
      htrans = 2'b00;
      hwrite = 1'b0;
      hsize  = 3'd2;
      hwdata = 32'h0;
      selIdx = 2'd0;

      repeat (2) @(posedge hclk);
      @(negedge hclk);
      for (int d = 0; d < 3; d++) begin
         checkOutput("rstReady", rdyVec[d], 1);
         checkOutput("rstResp", respVec[d], 0);
         checkOutput("rstRdata", rdataOf(d), 32'h0);
      end
      hrstn = 1'b1;

      repeat (5) pushTx(32'h0, 1'b0, 3'd2, 32'h0, 2'b00);
      applyStimulus(0, cyc);

      for (int d = 0; d < 3; d++) begin
         for (int w = 0; w < 16; w++) pushTx(32'(4 * w), 1'b1, 3'd2, 32'hA000_0000 + 32'(d * 256 + w), 2'b10);
         applyStimulus(d, cyc);
      end

      pushTx(32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, 2'b10);
      pushTx(32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
      applyStimulus(0, cyc);
      checkOutput("b2bCycles", cyc, 2);

      pushTx(32'h10, 1'b1, 3'd2, 32'h0000_0000, 2'b10);
      pushTx(32'h11, 1'b1, 3'd0, 32'h0000_AA00, 2'b11);
      pushTx(32'h12, 1'b1, 3'd1, 32'h1234_0000, 2'b11);
      pushTx(32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
      applyStimulus(0, cyc);

      pushTx(32'h04, 1'b0, 3'd2, 32'h0, 2'b10);
      pushTx(32'h08, 1'b0, 3'd2, 32'h0, 2'b11);
      pushTx(32'h0C, 1'b0, 3'd2, 32'h0, 2'b11);
      applyStimulus(1, cyc);
      checkOutput("pipeCycles", cyc, 9);

      pushTx(32'h12, 1'b1, 3'd2, 32'hFFFF_FFFF, 2'b10);
      pushTx(32'h10, 1'b1, 3'd3, 32'hFFFF_FFFF, 2'b10);
      pushTx(BASE + REGION, 1'b1, 3'd2, 32'hFFFF_FFFF, 2'b10);
      pushTx(32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
      pushTx(32'h00, 1'b0, 3'd2, 32'h0, 2'b10);
      applyStimulus(1, cyc);

      selIdx = 2'd2;
      @(negedge hclk);
      hsel = 3'b100; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
      @(negedge hclk);
      hsel = 3'b000; htrans = 2'b00; hwdata = 32'h5555_5555;
      checkOutput("rstWait1Ready", rdyVec[2], 0);
      @(negedge hclk);
      checkOutput("rstWait2Ready", rdyVec[2], 0);
      hrstn = 1'b0;
      @(negedge hclk);
      hrstn = 1'b1;
      checkOutput("midRstReady", rdyVec[2], 1);
      checkOutput("midRstResp", respVec[2], 0);
      checkOutput("midRstRdata", rdata2, 32'h0);
      pushTx(32'h20, 1'b0, 3'd2, 32'h0, 2'b10);
      applyStimulus(2, cyc);

      for (int d = 0; d < 3; d++) begin
         for (int n = 0; n < 40; n++) begin
            a  = ($urandom_range(0, 9) == 0) ? (BASE + REGION + 32'($urandom_range(0, 63))) : 32'($urandom_range(0, 63));
            sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0 && sz < 3'd3) a = a & ~((32'd1 << sz) - 32'd1);
            pushTx(a, 1'($urandom_range(0, 1)), sz, $urandom,
                   ($urandom_range(0, 6) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3)));
         end
         for (int w = 0; w < 16; w++) pushTx(32'(4 * w), 1'b0, 3'd2, 32'h0, 2'b11);
         applyStimulus(d, cyc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout: observed timeout, expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
